// File: rtl/axis_fifo_reader.sv
// axis_fifo_reader
//   Drain stage for a synchronous FIFO with a 1-cycle registered read port.
//   It issues pops, captures each returned word into a 2-entry in-order buffer
//   and presents the buffer head as an AXI4-Stream master. tlast marks every
//   PACKET_LEN-th beat. Two entries are enough for 1 beat/clk under tready=1.
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   enable            1 = issue new pops; 0 = no new pops, buffer still drains
//   fifo_empty        FIFO empty flag
//   fifo_pop          pop request (combinational)
//   fifo_data         FIFO read data, valid the cycle after a pop
//   m_axis_t*         AXI4-Stream master (tvalid/tready/tdata/tlast)
//   busy              buffer occupied or a read in flight
module axis_fifo_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int PACKET_LEN = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  busy
);
  localparam int CNT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PACKET_LEN - 1);

  logic [1:0][DATA_WIDTH-1:0] buf_q, buf_d;
  logic                       head_q, head_d;
  logic [1:0]                 occ_q, occ_d;
  logic                       inflight_q, inflight_d;
  logic [CNT_W-1:0]           beat_cnt_q, beat_cnt_d;

  logic       deq;
  logic [1:0] pending;
  logic       tail;

  always_comb begin
    deq     = (occ_q != 2'd0) & m_axis_tready;
    // Words already committed to the buffer: stored plus the one in flight.
    pending = occ_q + {1'b0, inflight_q};
    // A pop is safe when its word will find a free slot two edges later,
    // counting the slot freed by a dequeue this cycle.
    fifo_pop = ~reset & enable & ~fifo_empty &
               ((pending < 2'd2) | ((pending == 2'd2) & deq));

    buf_d      = buf_q;
    head_d     = head_q;
    occ_d      = occ_q;
    inflight_d = fifo_pop;
    beat_cnt_d = beat_cnt_q;

    // Tail slot is head+occ mod 2. With occ=2 a capture can only coincide
    // with a dequeue, so overwriting the departing head slot is correct.
    tail = head_q ^ occ_q[0];
    if (inflight_q) buf_d[tail] = fifo_data;

    if (deq) begin
      head_d     = ~head_q;
      beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;
    end

    case ({inflight_q, deq})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q      <= '0;
      head_q     <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      buf_q      <= buf_d;
      head_q     <= head_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign m_axis_tvalid = (occ_q != 2'd0);
  assign m_axis_tdata  = buf_q[head_q];
  assign m_axis_tlast  = (beat_cnt_q == LAST_BEAT) & m_axis_tvalid;
  assign busy          = (occ_q != 2'd0) | inflight_q;
endmodule

// File: tb/tb_axis_fifo_reader.sv
module tb_axis_fifo_reader;
  logic        clk = 1'b0;
  logic        reset, flush;
  logic        enable, fifo_empty, fifo_pop, tvalid, tready, tlast, busy;
  logic [31:0] fifo_data, tdata;

  logic        e_enable, e_empty, e_pop, e_tvalid, e_tready, e_tlast, e_busy;
  logic [31:0] e_fdata, e_tdata, e_word;

  always #5 clk = ~clk;

  axis_fifo_reader #(.DATA_WIDTH(32), .PACKET_LEN(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_pop(fifo_pop), .fifo_data(fifo_data), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tdata(tdata), .m_axis_tlast(tlast),
    .busy(busy));

  axis_fifo_reader #(.DATA_WIDTH(32), .PACKET_LEN(1)) dut1 (
    .clk(clk), .reset(reset), .enable(e_enable), .fifo_empty(e_empty),
    .fifo_pop(e_pop), .fifo_data(e_fdata), .m_axis_tvalid(e_tvalid),
    .m_axis_tready(e_tready), .m_axis_tdata(e_tdata), .m_axis_tlast(e_tlast),
    .busy(e_busy));

  // FIFO model for the main DUT: registered read, one word per pop.
  logic [31:0] mem [0:2047];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_pop) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Single-word FIFO model for the PACKET_LEN=1 instance.
  int e_pushed = 0;
  int e_taken  = 0;
  int e_out    = 0;
  bit e_on     = 0;
  assign e_empty = (e_pushed == e_taken);
  always @(posedge clk) begin
    if (e_pop) begin
      e_fdata <= e_word;
      e_taken <= e_taken + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int out_idx = 0;
  int tb_beat = 0;
  int last_cnt = 0;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
  logic [31:0] prev_d = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  // Called right after a negedge with inputs already driven: checks the
  // cycle's outputs, runs the scoreboards, then advances to the next negedge.
  task automatic step();
    #1;
    chk("occ_le2", dut.occ_q <= 2'd2, 1'b1);
    if (fifo_pop) chk("pop_while_empty", fifo_empty, 1'b0);
    if (prev_v && !prev_r) begin
      chk("hold_valid", tvalid, 1'b1);
      chk("hold_data", tdata, prev_d);
      chk("hold_last", tlast, prev_l);
    end
    if (tvalid && tready) begin
      chk("sb_data", tdata, mem[out_idx]);
      chk("sb_last", tlast, tb_beat == 15);
      if (tlast) last_cnt++;
      out_idx++;
      tb_beat = (tb_beat == 15) ? 0 : tb_beat + 1;
    end
    prev_v = tvalid; prev_r = tready; prev_d = tdata; prev_l = tlast;
    if (e_on) begin
      if (e_pop) chk("e_pop_while_empty", e_empty, 1'b0);
      if (e_tvalid) chk("e_last_valid", e_tlast, 1'b1);
      else          chk("e_last_idle", e_tlast, 1'b0);
      if (e_tvalid && e_tready) begin
        chk("e_data", e_tdata, 32'((e_out + 1) * 32'h111));
        e_out++;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input string name, input int maxc);
    int c = 0;
    enable = 1'b1;
    tready = 1'b1;
    while (!(out_idx == wr_ptr && !busy) && c < maxc) begin
      step();
      c++;
    end
    chk(name, out_idx, wr_ptr);
  endtask

  typedef struct {
    logic        en, rdy, pop, vld;
    logic [31:0] data;
    logic        last;
  } vec_t;
  vec_t tbl [20];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got timeout, expected test end");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b1; enable = 1'b0; tready = 1'b0;
    e_enable = 1'b0; e_tready = 1'b0; e_word = '0;

    // Streaming start-up then 10 cycles of backpressure, hand-derived.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0};
    for (int i = 2; i < 6; i++)   tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'(i - 1), 1'b0};
    for (int i = 6; i < 16; i++)  tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd5, 1'b0};
    for (int i = 16; i < 20; i++) tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'(i - 11), 1'b0};

    @(negedge clk); @(negedge clk);
    chk("rst_valid", tvalid, 1'b0);
    chk("rst_data", tdata, 32'd0);
    chk("rst_last", tlast, 1'b0);
    chk("rst_pop", fifo_pop, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_e_last", e_tlast, 1'b0);

    // Streaming 0x1..0x20 with backpressure in the middle.
    reset = 1'b0; flush = 1'b0;
    for (int i = 1; i <= 32; i++) push(32'(i));
    for (int i = 0; i < 20; i++) begin
      enable = tbl[i].en;
      tready = tbl[i].rdy;
      #1;
      chk("tbl_pop", fifo_pop, tbl[i].pop);
      chk("tbl_valid", tvalid, tbl[i].vld);
      chk("tbl_data", tdata, tbl[i].data);
      chk("tbl_last", tlast, tbl[i].last);
      if (i >= 7 && i < 16) chk("tbl_busy_full", dut.occ_q, 2'd2);
      step();
    end
    drain("stream_count", 200);
    chk("stream_tlast_count", last_cnt, 2);

    // enable dropped one cycle after a pop.
    enable = 1'b0;
    push(32'hA0); push(32'hA1); push(32'hA2);
    enable = 1'b1; tready = 1'b1;
    #1 chk("en_pop", fifo_pop, 1'b1);
    step();
    enable = 1'b0;
    #1 chk("en_off_pop", fifo_pop, 1'b0);
    chk("en_off_valid", tvalid, 1'b0);
    step();
    #1 chk("en_inflight_valid", tvalid, 1'b1);
    chk("en_inflight_data", tdata, 32'hA0);
    chk("en_inflight_pop", fifo_pop, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      #1 chk("en_idle_pop", fifo_pop, 1'b0);
      chk("en_idle_valid", tvalid, 1'b0);
      step();
    end
    drain("en_resume_count", 50);

    // Random tready and random refill, 1000 words.
    begin
      int pushed = 0;
      for (int c = 0; c < 20000; c++) begin
        if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
          push($urandom);
          pushed++;
        end
        enable = 1'b1;
        tready = 1'($urandom_range(0, 1));
        step();
        if (pushed == 1000 && out_idx == wr_ptr) break;
      end
      chk("rand_count", out_idx, wr_ptr);
    end
    drain("rand_drain", 20);

    // Reset mid-stream with the buffer full.
    enable = 1'b1; tready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'hB0 + 32'(i));
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_occ", dut.occ_q, 2'd2);
    chk("pre_rst_valid", tvalid, 1'b1);
    #2 reset = 1'b1; flush = 1'b1;
    #1 chk("mid_rst_valid", tvalid, 1'b0);
    chk("mid_rst_data", tdata, 32'd0);
    chk("mid_rst_last", tlast, 1'b0);
    chk("mid_rst_pop", fifo_pop, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0; flush = 1'b0;
    out_idx = wr_ptr; tb_beat = 0; last_cnt = 0;
    prev_v = 1'b0; prev_r = 1'b0;
    for (int i = 0; i < 16; i++) push(32'hC0 + 32'(i));
    drain("post_rst_count", 100);
    chk("post_rst_tlast_count", last_cnt, 1);

    // PACKET_LEN=1 instance with a single-word FIFO toggling empty.
    enable = 1'b0;
    e_on = 1;
    for (int c = 0; c < 80; c++) begin
      e_enable = 1'b1;
      if (e_empty && $urandom_range(0, 1) == 1) begin
        e_word = 32'((e_pushed + 1) * 32'h111);
        e_pushed++;
      end
      e_tready = 1'($urandom_range(0, 1));
      step();
    end
    e_tready = 1'b1;
    for (int c = 0; c < 50 && !(e_out == e_pushed && !e_busy); c++) step();
    chk("e_count", e_out, e_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
